// File: rtl/dw_window_stream_pkg.sv
// Shared sizing helpers and types for the depthwise window streamer.
// Output-grid sizes, window flattening order and index widths live here so RTL and users agree.
package dw_lut_pkg;

    localparam int PIX_DW = 8;

    typedef logic signed [PIX_DW-1:0] pixel_t;

    function automatic int calc_h_out(input int h, input int ksz, input int upscale);
        return (h - (ksz - 1)) / upscale;
    endfunction

    function automatic int calc_w_out(input int w, input int ksz, input int upscale);
        return (w - (ksz - 1)) / upscale;
    endfunction

    function automatic int calc_ksz_sq(input int ksz);
        return ksz * ksz;
    endfunction

    function automatic int win_idx(input int c, input int i, input int j, input int ksz);
        return (c * ksz + i) * ksz + j;
    endfunction

    // Never returns zero so single-entry dimensions still get a legal one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dw_window_stream_line_buf.sv
// One buffered image row: written at the current column, read combinationally before the write lands.
module dw_line_buf #(
    parameter int DEPTH = 48,
    parameter int PW    = 24,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [PW-1:0] wdata,
    output logic [PW-1:0] rdata
);

    logic [PW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dw_window_stream.sv
// Raster pixel stream in, KSZ x KSZ windows out at stride UPSCALE, one per LUT output site.
// Line buffers hold the previous KSZ-1 rows; a short column shift register completes each window.
module dw_window_stream
    import dw_lut_pkg::*;
#(
    parameter  int C       = 3,
    parameter  int H       = 48,
    parameter  int W       = 48,
    parameter  int KSZ     = 3,
    parameter  int UPSCALE = 2,
    parameter  int DW      = 8,
    localparam int H_OUT   = calc_h_out(H, KSZ, UPSCALE),
    localparam int W_OUT   = calc_w_out(W, KSZ, UPSCALE),
    localparam int KSZ_SQ  = calc_ksz_sq(KSZ),
    localparam int OHW     = idx_width(H_OUT),
    localparam int OWW     = idx_width(W_OUT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sof,
    input  logic [C*DW-1:0]          in_pix,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [C*KSZ_SQ*DW-1:0]   out_win,
    output logic [OHW-1:0]           out_h,
    output logic [OWW-1:0]           out_w,
    output logic                     out_eof
);

    localparam int PW  = C * DW;
    localparam int RW  = idx_width(H);
    localparam int CW  = idx_width(W);
    localparam int PHW = idx_width(UPSCALE);

    logic           accept, emit, synced_q, col_last, row_last;
    logic [RW-1:0]  row_q, hi_q, r_eff, hi_eff;
    logic [CW-1:0]  col_q, wi_q, c_eff, wi_eff;
    logic [PHW-1:0] rph_q, cph_q, rph_eff, cph_eff;

    logic [PW-1:0]  lb_rd [KSZ-1];
    logic [PW-1:0]  lb_wd [KSZ-1];
    logic [PW-1:0]  col_in [KSZ];
    logic [PW-1:0]  hist_q [KSZ][KSZ-1];
    logic [PW-1:0]  win_nxt [KSZ][KSZ];
    logic [C*KSZ_SQ*DW-1:0] win_flat;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A start-of-frame beat overrides every position and stride counter.
    always_comb begin
        r_eff   = in_sof ? '0 : row_q;
        c_eff   = in_sof ? '0 : col_q;
        hi_eff  = in_sof ? '0 : hi_q;
        wi_eff  = in_sof ? '0 : wi_q;
        rph_eff = in_sof ? '0 : rph_q;
        cph_eff = in_sof ? '0 : cph_q;
    end

    assign col_last = (c_eff == CW'(W - 1));
    assign row_last = (r_eff == RW'(H - 1));

    assign emit = accept && (synced_q || in_sof)
               && (r_eff >= RW'(KSZ - 1)) && (c_eff >= CW'(KSZ - 1))
               && (rph_eff == '0) && (cph_eff == '0)
               && (hi_eff < RW'(H_OUT)) && (wi_eff < CW'(W_OUT));

    // Phase counters stay at zero until the first full window row/column, then cycle modulo UPSCALE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q    <= '0;
            col_q    <= '0;
            hi_q     <= '0;
            wi_q     <= '0;
            rph_q    <= '0;
            cph_q    <= '0;
            synced_q <= 1'b0;
        end else if (accept) begin
            if (in_sof || (col_last && row_last)) begin
                synced_q <= 1'b1;
            end
            if (!col_last) begin
                col_q <= c_eff + CW'(1);
                row_q <= r_eff;
                hi_q  <= hi_eff;
                rph_q <= rph_eff;
                if (c_eff < CW'(KSZ - 1)) begin
                    cph_q <= '0;
                    wi_q  <= '0;
                end else if (cph_eff == PHW'(UPSCALE - 1)) begin
                    cph_q <= '0;
                    wi_q  <= wi_eff + CW'(1);
                end else begin
                    cph_q <= cph_eff + PHW'(1);
                    wi_q  <= wi_eff;
                end
            end else begin
                col_q <= '0;
                cph_q <= '0;
                wi_q  <= '0;
                if (row_last || (r_eff < RW'(KSZ - 1))) begin
                    row_q <= row_last ? '0 : r_eff + RW'(1);
                    rph_q <= '0;
                    hi_q  <= '0;
                end else if (rph_eff == PHW'(UPSCALE - 1)) begin
                    row_q <= r_eff + RW'(1);
                    rph_q <= '0;
                    hi_q  <= hi_eff + RW'(1);
                end else begin
                    row_q <= r_eff + RW'(1);
                    rph_q <= rph_eff + PHW'(1);
                    hi_q  <= hi_eff;
                end
            end
        end
    end

    // Buffer 0 holds the previous row; each later buffer takes what the one before it held.
    for (genvar k = 0; k < KSZ - 1; k++) begin : g_lb
        if (k == 0) begin : g_first
            assign lb_wd[k] = in_pix;
        end else begin : g_next
            assign lb_wd[k] = lb_rd[k-1];
        end
        dw_line_buf #(.DEPTH(W), .PW(PW), .AW(CW)) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (c_eff),
            .wdata (lb_wd[k]),
            .rdata (lb_rd[k])
        );
        assign col_in[k] = lb_rd[KSZ-2-k];
    end
    assign col_in[KSZ-1] = in_pix;

    always_comb begin
        for (int i = 0; i < KSZ; i++) begin
            for (int j = 0; j < KSZ - 1; j++) begin
                win_nxt[i][j] = hist_q[i][j];
            end
            win_nxt[i][KSZ-1] = col_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < KSZ; i++) begin
                for (int j = 0; j < KSZ - 1; j++) begin
                    hist_q[i][j] <= win_nxt[i][j+1];
                end
            end
        end
    end

    always_comb begin
        win_flat = '0;
        for (int ch = 0; ch < C; ch++) begin
            for (int i = 0; i < KSZ; i++) begin
                for (int j = 0; j < KSZ; j++) begin
                    win_flat[win_idx(ch, i, j, KSZ)*DW +: DW] = win_nxt[i][j][ch*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_win   <= '0;
            out_h     <= '0;
            out_w     <= '0;
            out_eof   <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_win   <= win_flat;
            out_h     <= OHW'(hi_eff);
            out_w     <= OWW'(wi_eff);
            out_eof   <= (hi_eff == RW'(H_OUT - 1)) && (wi_eff == CW'(W_OUT - 1));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
